// File: rtl/lz4_pkg.sv
// Shared types and widths for the LZ4 sequence scheduler.
// Holds the FSM state encoding and the literal word-count helper.
package lz4_pkg;

  localparam int OFS_W   = 16;
  localparam int LEN_W   = 32;
  // ceil((2^32-1)/4) = 2^30, which needs 31 bits
  localparam int WORDS_W = LEN_W - 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_SEQ,
    ISSUE,
    LIT,
    WAIT_SEG,
    FLUSH,
    DONE
  } state_t;

  function automatic logic [WORDS_W-1:0] ceil_words(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_W+1)'(3);
    return sum[LEN_W:2];
  endfunction

endpackage

// File: rtl/lz4_lit_counter.sv
// Remaining literal-word counter: loads ceil(len/4), counts down on each beat.
// Load has priority over decrement; the count never wraps below zero.
module lz4_lit_counter
  import lz4_pkg::*;
(
  input  logic             clk,
  input  logic             rstN,
  input  logic             load,
  input  logic [LEN_W-1:0] unmatch_len,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  logic [WORDS_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      count <= '0;
    end else if (load) begin
      count <= ceil_words(unmatch_len);
    end else if (dec && (count != '0)) begin
      count <= count - WORDS_W'(1);
    end
  end

  assign zero = (count == '0);
  assign last = (count == WORDS_W'(1));

endmodule

// File: rtl/lz4_seq_scheduler.sv
// Frame sequencer between the match finder, literal FIFO and LZ4 encoder.
// Literal words pass FIFO->encoder combinationally; empty FIFO stalls without penalty.
module lz4_seq_scheduler
  import lz4_pkg::*;
(
  input  logic             clk,
  input  logic             rstN,
  input  logic             frame_start,
  input  logic             frame_end,
  input  logic             seq_valid,
  output logic             seq_ready,
  input  logic [OFS_W-1:0] seq_offset,
  input  logic [LEN_W-1:0] seq_match_len,
  input  logic [LEN_W-1:0] seq_unmatch_len,
  input  logic [31:0]      lit_data,
  input  logic             lit_empty,
  output logic             lit_rd_en,
  output logic [OFS_W-1:0] match_offset,
  output logic [LEN_W-1:0] match_length,
  output logic [LEN_W-1:0] unmatch_length,
  output logic             info_valid,
  output logic [31:0]      unmatch_data,
  output logic             data_valid,
  output logic             encode_en,
  output logic             compress_start,
  output logic             compress_done,
  input  logic             seg_done,
  input  logic             encode_done,
  input  logic             encode_busy,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      seq_count
);

  state_t           state;
  state_t           state_nxt;
  logic             pending;
  logic [OFS_W-1:0] ofs_q;
  logic [LEN_W-1:0] mlen_q;
  logic [LEN_W-1:0] ulen_q;
  logic             accept;
  logic             lit_zero;
  logic             lit_last;

  assign accept = (state == WAIT_SEQ) && seq_valid;

  lz4_lit_counter u_lit_counter (
    .clk         (clk),
    .rstN        (rstN),
    .load        (accept),
    .unmatch_len (seq_unmatch_len),
    .dec         (data_valid),
    .zero        (lit_zero),
    .last        (lit_last)
  );

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state     <= IDLE;
      pending   <= 1'b0;
      ofs_q     <= '0;
      mlen_q    <= '0;
      ulen_q    <= '0;
      seq_count <= '0;
    end else begin
      state <= state_nxt;
      // DONE wins so a late frame_end cannot leak into the next frame
      if (state == DONE) begin
        pending <= 1'b0;
      end else if ((state != IDLE) && frame_end) begin
        pending <= 1'b1;
      end
      if (accept) begin
        ofs_q  <= seq_offset;
        mlen_q <= seq_match_len;
        ulen_q <= seq_unmatch_len;
      end
      if (state == START) begin
        seq_count <= '0;
      end else if (state == ISSUE) begin
        seq_count <= seq_count + 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    seq_ready      = 1'b0;
    lit_rd_en      = 1'b0;
    match_offset   = '0;
    match_length   = '0;
    unmatch_length = '0;
    info_valid     = 1'b0;
    unmatch_data   = '0;
    data_valid     = 1'b0;
    compress_start = 1'b0;
    compress_done  = 1'b0;
    frame_done     = 1'b0;
    encode_en      = (state != IDLE);
    busy           = (state != IDLE);

    case (state)
      IDLE: begin
        if (frame_start) state_nxt = START;
      end
      START: begin
        compress_start = 1'b1;
        state_nxt      = WAIT_SEQ;
      end
      WAIT_SEQ: begin
        seq_ready = 1'b1;
        if (seq_valid) begin
          state_nxt = ISSUE;
        end else if (pending && !encode_busy) begin
          state_nxt = FLUSH;
        end
      end
      ISSUE: begin
        info_valid     = 1'b1;
        match_offset   = ofs_q;
        match_length   = mlen_q;
        unmatch_length = ulen_q;
        state_nxt      = lit_zero ? WAIT_SEG : LIT;
      end
      LIT: begin
        data_valid   = !lit_empty && !lit_zero;
        lit_rd_en    = data_valid;
        unmatch_data = data_valid ? lit_data : '0;
        if (data_valid && lit_last) state_nxt = WAIT_SEG;
      end
      WAIT_SEG: begin
        if (seg_done) state_nxt = WAIT_SEQ;
      end
      FLUSH: begin
        compress_done = 1'b1;
        if (encode_done) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lz4_seq_scheduler.sv
// Bench for lz4_seq_scheduler: vector table, hand-built corner sequences and
// randomized frames scored against a transaction-level expectation.
module tb_lz4_seq_scheduler;

  logic        clk = 1'b0;
  logic        rstN;
  logic        frame_start, frame_end;
  logic        seq_valid, seq_ready;
  logic [15:0] seq_offset;
  logic [31:0] seq_match_len, seq_unmatch_len;
  logic [31:0] lit_data;
  logic        lit_empty, lit_rd_en;
  logic [15:0] match_offset;
  logic [31:0] match_length, unmatch_length;
  logic        info_valid;
  logic [31:0] unmatch_data;
  logic        data_valid, encode_en, compress_start, compress_done;
  logic        seg_done, encode_done, encode_busy;
  logic        busy, frame_done;
  logic [15:0] seq_count;
  logic        outs_any;

  int tests = 0;
  int fails = 0;

  logic [15:0] s_ofs  [0:63];
  logic [31:0] s_mlen [0:63];
  logic [31:0] s_ulen [0:63];
  int          s_beats[0:63];

  typedef struct {
    logic [15:0] ofs;
    logic [31:0] mlen;
    logic [31:0] ulen;
    int          empty_mode;
    int          exp_beats;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  lz4_seq_scheduler dut (
    .clk             (clk),
    .rstN            (rstN),
    .frame_start     (frame_start),
    .frame_end       (frame_end),
    .seq_valid       (seq_valid),
    .seq_ready       (seq_ready),
    .seq_offset      (seq_offset),
    .seq_match_len   (seq_match_len),
    .seq_unmatch_len (seq_unmatch_len),
    .lit_data        (lit_data),
    .lit_empty       (lit_empty),
    .lit_rd_en       (lit_rd_en),
    .match_offset    (match_offset),
    .match_length    (match_length),
    .unmatch_length  (unmatch_length),
    .info_valid      (info_valid),
    .unmatch_data    (unmatch_data),
    .data_valid      (data_valid),
    .encode_en       (encode_en),
    .compress_start  (compress_start),
    .compress_done   (compress_done),
    .seg_done        (seg_done),
    .encode_done     (encode_done),
    .encode_busy     (encode_busy),
    .busy            (busy),
    .frame_done      (frame_done),
    .seq_count       (seq_count)
  );

  assign outs_any = |{seq_ready, lit_rd_en, match_offset, match_length, unmatch_length,
                      info_valid, unmatch_data, data_valid, encode_en, compress_start,
                      compress_done, busy, frame_done, seq_count};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    frame_start = 0; frame_end = 0; seq_valid = 0;
    seq_offset = 0; seq_match_len = 0; seq_unmatch_len = 0;
    lit_data = 0; lit_empty = 1; seg_done = 0; encode_done = 0; encode_busy = 0;
  endtask

  // Drives one frame of n sequences from s_* and scores what the encoder side sees.
  task automatic run_frame(input int n, input int empty_mode, input int fe_mode, input int gaps);
    int sent = 0, k = 0, beats = 0, cs_cnt = 0, fd_cnt = 0, cyc = 0, fe_wait;
    int v_info = 0, v_dv = 0, v_data = 0, v_rdy = 0, v_busy = 0, v_flush = 0;
    bit presenting = 0, fe_sent = 0, finished = 0;
    bit prev_cd = 0, prev_ed = 0, prev_eb = 0;
    fe_wait = int'($urandom_range(0, 5));
    while (!finished) begin
      frame_start = (cyc == 0) || ($urandom_range(0, 15) == 0);
      frame_end   = 0;
      if (!presenting && sent < n && cyc >= 2 && (gaps == 0 || $urandom_range(0, 1) == 0)) begin
        presenting      = 1;
        seq_offset      = s_ofs[sent];
        seq_match_len   = s_mlen[sent];
        seq_unmatch_len = s_ulen[sent];
        if (fe_mode == 0 && sent == n - 1) begin
          frame_end = 1;
          fe_sent   = 1;
        end
      end
      if (fe_mode == 1 && sent == n && !fe_sent) begin
        if (fe_wait == 0) begin
          frame_end = 1;
          fe_sent   = 1;
        end else begin
          fe_wait--;
        end
      end
      seq_valid   = presenting;
      lit_empty   = (empty_mode == 0) ? 1'b0 :
                    (empty_mode == 1) ? (cyc % 2 == 1) : ($urandom_range(0, 2) == 0);
      lit_data    = $urandom;
      seg_done    = ($urandom_range(0, 3) == 0);
      encode_done = ($urandom_range(0, 2) == 0);
      encode_busy = ($urandom_range(0, 2) == 0);

      @(negedge clk);
      if (compress_start) cs_cnt++;
      if (info_valid) begin
        if (k < n) begin
          chk("info_offset", match_offset, s_ofs[k]);
          chk("info_match_len", match_length, s_mlen[k]);
          chk("info_unmatch_len", unmatch_length, s_ulen[k]);
        end
        if (k > 0) chk("lit_beats", beats, s_beats[k-1]);
        beats = 0;
        k++;
      end else if ((match_offset != 0) || (match_length != 0) || (unmatch_length != 0)) begin
        v_info++;
      end
      if (data_valid) begin
        beats++;
        if (lit_empty) v_dv++;
        if (unmatch_data !== lit_data) v_data++;
      end else if (unmatch_data != 0) begin
        v_data++;
      end
      if (lit_rd_en !== data_valid) v_dv++;
      if (seq_ready && info_valid) v_rdy++;
      if (cyc == 0 && (busy || encode_en)) v_busy++;
      if (cyc >= 1 && (!busy || !encode_en)) v_busy++;
      if (compress_done && !prev_cd && prev_eb) v_flush++;
      if (compress_done && sent < n) v_flush++;
      if (prev_cd && !prev_ed && !compress_done) v_flush++;
      if (frame_done) begin
        fd_cnt++;
        if (!(prev_cd && prev_ed)) v_flush++;
        finished = 1;
      end
      prev_cd = compress_done;
      prev_ed = encode_done;
      prev_eb = encode_busy;
      if (seq_valid && seq_ready) begin
        presenting = 0;
        sent++;
      end
      cyc++;
      if (!finished && cyc > 3000) begin
        chk("frame_timeout", 1, 0);
        finished = 1;
      end
      tick();
    end
    if (k > 0) chk("lit_beats_last", beats, s_beats[k-1]);
    chk("info_count", k, n);
    chk("compress_start_pulses", cs_cnt, 1);
    chk("frame_done_pulses", fd_cnt, 1);
    chk("info_idle_zero", v_info, 0);
    chk("data_valid_rules", v_dv, 0);
    chk("unmatch_data_rules", v_data, 0);
    chk("ready_vs_info", v_rdy, 0);
    chk("busy_encode_en", v_busy, 0);
    chk("flush_rules", v_flush, 0);
    clear_inputs();
    @(negedge clk);
    chk("idle_after_frame", busy, 0);
    chk("seq_count_frame", seq_count, 16'(n));
    tick();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, cnt2, n;
    tbl[0] = '{16'h0C04, 32'd267,        32'd3,  0, 1};
    tbl[1] = '{16'h0001, 32'd5,          32'd0,  0, 0};
    tbl[2] = '{16'h0007, 32'd4,          32'd76, 1, 19};
    tbl[3] = '{16'hFFFF, 32'hFFFF_FFFF,  32'd4,  2, 1};
    tbl[4] = '{16'h0002, 32'd0,          32'd5,  2, 2};
    tbl[5] = '{16'h0009, 32'd9,          32'd1,  1, 1};
    tbl[6] = '{16'h1234, 32'd16,         32'd8,  0, 2};

    clear_inputs();
    rstN = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_state", outs_any, 0);

    // Frame start accepted in the very first cycle after reset release
    rstN = 1;
    frame_start = 1;
    tick();
    frame_start = 0;
    @(negedge clk);
    chk("start_after_reset", compress_start, 1);
    chk("seq_count_cleared", seq_count, 0);
    tick();
    rstN = 0;
    tick();
    rstN = 1;
    @(negedge clk);
    chk("reset_mid_frame", outs_any, 0);
    tick();

    // One 3-byte literal sequence, held in WAIT_SEG, then encode_busy delaying flush
    frame_start = 1;
    tick();
    frame_start = 0;
    @(negedge clk);
    chk("hc_start_pulse", compress_start, 1);
    tick();
    seq_valid = 1; seq_offset = 16'h0C04; seq_match_len = 32'd267; seq_unmatch_len = 32'd3;
    @(negedge clk);
    chk("hc_seq_ready", seq_ready, 1);
    tick();
    seq_valid = 0; lit_empty = 0; lit_data = 32'hA5A5_0001;
    @(negedge clk);
    chk("hc_info_valid", info_valid, 1);
    chk("hc_info_offset", match_offset, 16'h0C04);
    chk("hc_info_mlen", match_length, 32'd267);
    chk("hc_info_ulen", unmatch_length, 32'd3);
    tick();
    @(negedge clk);
    chk("hc_data_valid", data_valid, 1);
    chk("hc_unmatch_data", unmatch_data, 32'hA5A5_0001);
    tick();
    cnt = 0; cnt2 = 0;
    repeat (10) begin
      @(negedge clk);
      if (data_valid || lit_rd_en) cnt++;
      if (seq_ready || !busy) cnt2++;
      tick();
    end
    chk("hc_no_extra_reads", cnt, 0);
    chk("hc_wait_seg_hold", cnt2, 0);
    seg_done = 1;
    tick();
    seg_done = 0;
    @(negedge clk);
    chk("hc_back_to_wait_seq", seq_ready, 1);
    chk("hc_seq_count", seq_count, 1);
    frame_end = 1; encode_busy = 1;
    tick();
    frame_end = 0;
    cnt = 0;
    repeat (3) begin
      tick();
      @(negedge clk);
      if (compress_done) cnt++;
    end
    chk("hc_busy_holds_flush", cnt, 0);
    encode_busy = 0;
    tick();
    @(negedge clk);
    chk("hc_flush_entered", compress_done, 1);
    cnt = 0;
    repeat (3) begin
      tick();
      @(negedge clk);
      if (compress_done) cnt++;
    end
    chk("hc_compress_done_held", cnt, 3);
    encode_done = 1;
    tick();
    encode_done = 0;
    @(negedge clk);
    chk("hc_frame_done", frame_done, 1);
    chk("hc_flush_dropped", compress_done, 0);
    tick();
    @(negedge clk);
    chk("hc_idle", busy | frame_done, 0);
    tick();

    // Max unmatch length needs the wide add: must enter LIT, then reset mid-LIT
    frame_start = 1;
    tick();
    frame_start = 0;
    tick();
    seq_valid = 1; seq_offset = 16'h0042; seq_match_len = 32'd4; seq_unmatch_len = 32'hFFFF_FFFF;
    lit_empty = 0;
    tick();
    seq_valid = 0;
    @(negedge clk);
    chk("ovf_issue", info_valid, 1);
    tick();
    cnt = 0;
    repeat (5) begin
      lit_data = $urandom;
      @(negedge clk);
      if (lit_rd_en) cnt++;
      tick();
    end
    chk("ovf_lit_beats", cnt, 5);
    rstN = 0;
    tick();
    rstN = 1;
    lit_empty = 1;
    @(negedge clk);
    chk("reset_mid_lit", outs_any, 0);
    tick();

    for (int i = 0; i < 7; i++) begin
      s_ofs[0]   = tbl[i].ofs;
      s_mlen[0]  = tbl[i].mlen;
      s_ulen[0]  = tbl[i].ulen;
      s_beats[0] = tbl[i].exp_beats;
      run_frame(1, tbl[i].empty_mode, 0, 0);
    end

    for (int f = 0; f < 20; f++) begin
      n = int'($urandom_range(1, 6));
      for (int j = 0; j < n; j++) begin
        s_ofs[j]   = 16'($urandom);
        s_mlen[j]  = $urandom;
        s_ulen[j]  = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
        s_beats[j] = int'(({1'b0, s_ulen[j]} + 33'd3) / 33'd4);
      end
      run_frame(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
